// File: rtl/apb4_pkg.sv
// Shared APB4 constants: protection bits, default bus widths and timeout.
// Also holds the width helper for the saturating timeout counter.
package apb4_pkg;

    localparam int APB_ADDR_WIDTH = 32;
    localparam int APB_DATA_WIDTH = 32;
    localparam int APB_TIMEOUT    = 16;

    localparam logic [2:0] PPROT_PRIV   = 3'b001;
    localparam logic [2:0] PPROT_NONSEC = 3'b010;
    localparam logic [2:0] PPROT_INSTR  = 3'b100;

    // Bits needed to hold 0..limit; a disabled timeout still gets one bit.
    function automatic int cnt_width(input int limit);
        return (limit > 0) ? $clog2(limit + 1) : 1;
    endfunction

endpackage

// File: rtl/apb4_cmd_master_if.sv
// Command, response and APB4 initiator signals of the command master.
// master = the bridge itself, slave = the command source plus APB target side.
interface apb4_cmd_master_if
    import apb4_pkg::*;
#(
    parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH = APB_DATA_WIDTH
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic                  cmd_write_i;
    logic [ADDR_WIDTH-1:0] cmd_addr_i;
    logic [DATA_WIDTH-1:0] cmd_wdata_i;
    logic [STRB_WIDTH-1:0] cmd_wstrb_i;
    logic [2:0]            cmd_prot_i;

    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [DATA_WIDTH-1:0] rsp_rdata_o;
    logic                  rsp_err_o;

    logic [ADDR_WIDTH-1:0] paddr_o;
    logic [2:0]            pprot_o;
    logic                  psel_o;
    logic                  penable_o;
    logic                  pwrite_o;
    logic [DATA_WIDTH-1:0] pwdata_o;
    logic [STRB_WIDTH-1:0] pstrb_o;
    logic                  pready_i;
    logic [DATA_WIDTH-1:0] prdata_i;
    logic                  pslverr_i;

    modport master (
        input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_wstrb_i, cmd_prot_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  rsp_ready_i,
        output paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o,
        input  pready_i, prdata_i, pslverr_i
    );

    modport slave (
        output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_wstrb_i, cmd_prot_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output rsp_ready_i,
        input  paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o,
        output pready_i, prdata_i, pslverr_i
    );

endinterface

// File: rtl/apb4_timeout_cnt.sv
// Saturating wait-state counter; expired flags the cycle whose stall reaches TIMEOUT.
// Combinational expired, one-cycle counter update; TIMEOUT=0 never expires.
module apb4_timeout_cnt
    import apb4_pkg::*;
#(
    parameter int TIMEOUT = APB_TIMEOUT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int            CW    = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (TIMEOUT > 0) && enable && !clear && (cnt_d == LIMIT);

endmodule

// File: rtl/apb4_cmd_master.sv
// Turns single commands into APB4 transfers: 3 cycles to response with no waits.
// One transfer in flight; cmd_ready only in IDLE, response held until rsp_ready.
module apb4_cmd_master
    import apb4_pkg::*;
#(
    parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH = APB_DATA_WIDTH,
    parameter int TIMEOUT    = APB_TIMEOUT
) (
    input logic               clk_i,
    input logic               rst_i,
    apb4_cmd_master_if.master bus
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

    state_e                state_q,     state_d;
    logic [ADDR_WIDTH-1:0] paddr_q,     paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q,    pwdata_d;
    logic [STRB_WIDTH-1:0] pstrb_q,     pstrb_d;
    logic [2:0]            pprot_q,     pprot_d;
    logic                  pwrite_q,    pwrite_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q,   rsp_err_d;

    logic cmd_ready;
    logic cmd_fire;
    logic to_expired;

    // Gated by reset so every output reads 0 while reset is held.
    assign cmd_ready = (state_q == IDLE) && !rst_i;
    assign cmd_fire  = bus.cmd_valid_i && cmd_ready;

    apb4_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear   (state_q == SETUP),
        .enable  ((state_q == ACCESS) && !bus.pready_i),
        .expired (to_expired)
    );

    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        pprot_d     = pprot_q;
        pwrite_d    = pwrite_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    state_d  = SETUP;
                    paddr_d  = bus.cmd_addr_i;
                    pwdata_d = bus.cmd_wdata_i;
                    pstrb_d  = bus.cmd_write_i ? bus.cmd_wstrb_i : '0;
                    pprot_d  = bus.cmd_prot_i;
                    pwrite_d = bus.cmd_write_i;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                // A ready in the final allowed cycle beats the timeout.
                if (bus.pready_i) begin
                    state_d     = RESP;
                    rsp_rdata_d = pwrite_q ? '0 : bus.prdata_i;
                    rsp_err_d   = bus.pslverr_i;
                end else if (to_expired) begin
                    state_d     = RESP;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            pprot_q     <= '0;
            pwrite_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            pprot_q     <= pprot_d;
            pwrite_q    <= pwrite_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.cmd_ready_o = cmd_ready;
    assign bus.rsp_valid_o = (state_q == RESP);
    assign bus.rsp_rdata_o = rsp_rdata_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.psel_o      = (state_q == SETUP) || (state_q == ACCESS);
    assign bus.penable_o   = (state_q == ACCESS);
    assign bus.paddr_o     = paddr_q;
    assign bus.pwdata_o    = pwdata_q;
    assign bus.pstrb_o     = pstrb_q;
    assign bus.pprot_o     = pprot_q;
    assign bus.pwrite_o    = pwrite_q;

endmodule

// File: tb/tb_apb4_cmd_master.sv
// Bench for apb4_cmd_master: directed vector table, reset-abort sequence,
// then random transfers checked against a latency/response model.
module tb_apb4_cmd_master;
    import apb4_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    apb4_cmd_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb4_cmd_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
        logic [2:0]    prot;
        int            n_wait;
        logic          slverr;
        logic [DW-1:0] rdata;
        int            rsp_delay;
    } xfer_t;

    typedef struct {
        xfer_t         x;
        int            cyc;
        logic [DW-1:0] rdata;
        logic          err;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic xfer_t mk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                 input logic [SW-1:0] ws, input logic [2:0] pr, input int nw,
                                 input logic se, input logic [DW-1:0] rd, input int dly);
        xfer_t t;
        t.write = w;  t.addr = a;    t.wdata = wd; t.wstrb = ws; t.prot = pr;
        t.n_wait = nw; t.slverr = se; t.rdata = rd; t.rsp_delay = dly;
        return t;
    endfunction

    // Response cycle counted from the acceptance cycle, plus response contents.
    function automatic void model(input xfer_t t, output int cyc, output logic [DW-1:0] rd,
                                  output logic err);
        if (TO > 0 && t.n_wait >= TO) begin
            cyc = 2 + TO;
            rd  = '0;
            err = 1'b1;
        end else begin
            cyc = 3 + t.n_wait;
            rd  = t.write ? '0 : t.rdata;
            err = t.slverr;
        end
    endfunction

    task automatic run_xfer(input xfer_t t, input int cyc, input logic [DW-1:0] erd, input logic eerr);
        int last;
        last = cyc + t.rsp_delay;
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            chk("cmd_ready", 64'(bus.cmd_ready_o), 64'(c == 0));
            chk("psel",      64'(bus.psel_o),      64'(c >= 1 && c < cyc));
            chk("penable",   64'(bus.penable_o),   64'(c >= 2 && c < cyc));
            chk("rsp_valid", 64'(bus.rsp_valid_o), 64'(c >= cyc));
            if (c >= 1 && c < cyc) begin
                chk("paddr",  64'(bus.paddr_o),  64'(t.addr));
                chk("pwrite", 64'(bus.pwrite_o), 64'(t.write));
                chk("pprot",  64'(bus.pprot_o),  64'(t.prot));
                chk("pstrb",  64'(bus.pstrb_o),  t.write ? 64'(t.wstrb) : 64'd0);
                if (t.write) chk("pwdata", 64'(bus.pwdata_o), 64'(t.wdata));
            end
            if (c >= cyc) begin
                chk("rsp_rdata", 64'(bus.rsp_rdata_o), 64'(erd));
                chk("rsp_err",   64'(bus.rsp_err_o),   64'(eerr));
            end
            bus.cmd_valid_i = (c == 0);
            if (c == 0) begin
                bus.cmd_write_i = t.write;
                bus.cmd_addr_i  = t.addr;
                bus.cmd_wdata_i = t.wdata;
                bus.cmd_wstrb_i = t.wstrb;
                bus.cmd_prot_i  = t.prot;
            end else begin
                bus.cmd_write_i = 1'($urandom);
                bus.cmd_addr_i  = $urandom;
                bus.cmd_wdata_i = $urandom;
                bus.cmd_wstrb_i = SW'($urandom);
                bus.cmd_prot_i  = 3'($urandom);
            end
            if (c >= 2 && c < cyc) begin
                bus.pready_i  = (c == 2 + t.n_wait);
                bus.prdata_i  = (c == 2 + t.n_wait) ? t.rdata : $urandom;
                bus.pslverr_i = (c == 2 + t.n_wait) ? t.slverr : 1'($urandom);
            end else begin
                bus.pready_i  = 1'($urandom);
                bus.prdata_i  = $urandom;
                bus.pslverr_i = 1'($urandom);
            end
            bus.rsp_ready_i = (c >= cyc) ? (c == last) : 1'($urandom);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cmd_ready"}, 64'(bus.cmd_ready_o), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid_o), 64'd0);
        chk({tag, "_rsp_rdata"}, 64'(bus.rsp_rdata_o), 64'd0);
        chk({tag, "_rsp_err"},   64'(bus.rsp_err_o),   64'd0);
        chk({tag, "_psel"},      64'(bus.psel_o),      64'd0);
        chk({tag, "_penable"},   64'(bus.penable_o),   64'd0);
        chk({tag, "_paddr"},     64'(bus.paddr_o),     64'd0);
        chk({tag, "_pwrite"},    64'(bus.pwrite_o),    64'd0);
        chk({tag, "_pwdata"},    64'(bus.pwdata_o),    64'd0);
        chk({tag, "_pstrb"},     64'(bus.pstrb_o),     64'd0);
        chk({tag, "_pprot"},     64'(bus.pprot_o),     64'd0);
    endtask

    initial begin
        xfer_t         t;
        int            ecyc;
        logic [DW-1:0] erd;
        logic          eerr;

        //                 wr    addr          wdata         strb  prot nw  se    rdata         dly
        vecs[0].x = mk(1'b1, 32'h0000_0004, 32'h0000_00A5, 4'hF, 3'd0, 0,  1'b0, 32'hDEAD_BEEF, 0);
        vecs[0].cyc = 3;  vecs[0].rdata = 32'h0;          vecs[0].err = 1'b0;
        vecs[1].x = mk(1'b0, 32'h0000_0000, 32'h0000_0055, 4'hF, 3'd0, 3,  1'b0, 32'h101F_1010, 0);
        vecs[1].cyc = 6;  vecs[1].rdata = 32'h101F_1010;  vecs[1].err = 1'b0;
        vecs[2].x = mk(1'b0, 32'h0000_0010, 32'h0,         4'h0, PPROT_PRIV, 0, 1'b1, 32'h0000_1234, 1);
        vecs[2].cyc = 3;  vecs[2].rdata = 32'h0000_1234;  vecs[2].err = 1'b1;
        vecs[3].x = mk(1'b1, 32'h0000_0020, 32'h1122_3344, 4'h5, PPROT_NONSEC, 0, 1'b0, 32'h5555_5555, 0);
        vecs[3].cyc = 3;  vecs[3].rdata = 32'h0;          vecs[3].err = 1'b0;
        vecs[4].x = mk(1'b0, 32'h0000_0030, 32'h0,         4'h0, 3'd0, 20, 1'b0, 32'hCAFE_F00D, 0);
        vecs[4].cyc = 18; vecs[4].rdata = 32'h0;          vecs[4].err = 1'b1;
        vecs[5].x = mk(1'b1, 32'h0000_0034, 32'h0BAD_CAFE, 4'hF, 3'd0, 15, 1'b0, 32'hFFFF_FFFF, 0);
        vecs[5].cyc = 18; vecs[5].rdata = 32'h0;          vecs[5].err = 1'b0;
        vecs[6].x = mk(1'b0, 32'h0000_0038, 32'h0,         4'h0, PPROT_INSTR, 0, 1'b1, 32'hA5A5_0001, 5);
        vecs[6].cyc = 3;  vecs[6].rdata = 32'hA5A5_0001;  vecs[6].err = 1'b1;
        vecs[7].x = mk(1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'h3, 3'd7, 1,  1'b1, 32'h1357_9BDF, 2);
        vecs[7].cyc = 4;  vecs[7].rdata = 32'h0;          vecs[7].err = 1'b1;
        vecs[8].x = mk(1'b0, 32'h0000_0044, 32'h0,         4'h0, 3'd0, 16, 1'b0, 32'h2468_ACE0, 0);
        vecs[8].cyc = 18; vecs[8].rdata = 32'h0;          vecs[8].err = 1'b1;

        bus.cmd_valid_i = 1'b0; bus.cmd_write_i = 1'b0; bus.cmd_addr_i = '0;
        bus.cmd_wdata_i = '0;   bus.cmd_wstrb_i = '0;   bus.cmd_prot_i = '0;
        bus.rsp_ready_i = 1'b0; bus.pready_i = 1'b0;    bus.prdata_i = '0; bus.pslverr_i = 1'b0;

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_cmd_ready", 64'(bus.cmd_ready_o), 64'd1);

        foreach (vecs[i]) run_xfer(vecs[i].x, vecs[i].cyc, vecs[i].rdata, vecs[i].err);

        // Reset pulse during ACCESS: transfer is dropped with no response.
        @(negedge clk);
        chk("rst_seq_cmd_ready", 64'(bus.cmd_ready_o), 64'd1);
        bus.cmd_valid_i = 1'b1; bus.cmd_write_i = 1'b0; bus.cmd_addr_i = 32'h0000_0040;
        bus.pready_i = 1'b0;
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        chk("rst_seq_setup_psel", 64'(bus.psel_o), 64'd1);
        @(negedge clk);
        chk("rst_seq_access_penable", 64'(bus.penable_o), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("rst_mid");
        rst = 1'b0;
        bus.pready_i = 1'b1;
        @(negedge clk);
        chk("rst_after_cmd_ready", 64'(bus.cmd_ready_o), 64'd1);
        bus.pready_i = 1'b0;
        repeat (3) begin
            chk("rst_after_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
            chk("rst_after_psel",      64'(bus.psel_o),      64'd0);
            @(negedge clk);
        end

        for (int n = 0; n < 40; n++) begin
            t = mk(1'($urandom), $urandom, $urandom, SW'($urandom), 3'($urandom),
                   ($urandom_range(0, 5) == 0) ? int'($urandom_range(14, 18)) : int'($urandom_range(0, 4)),
                   1'($urandom), $urandom, int'($urandom_range(0, 3)));
            model(t, ecyc, erd, eerr);
            run_xfer(t, ecyc, erd, eerr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
